dma_priority_resolver: RTL

DMA_PRIORITY_RESOLVER -- requirements
Module: dma_priority_resolver

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_prio_arbiter.sv | 31 +++
 rtl/dma_priority_resolver.sv | 119 +++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA priority resolver.
package dma_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } dma_state_t;

  // Channel that follows the given one in rotating order, wrapping 3 -> 0.
  function automatic ch_idx_t next_ch(input ch_idx_t ch);
    return ch_idx_t'(ch + 2'd1);
  endfunction

endpackage

// File: rtl/dma_prio_arbiter.sv
// Combinational picker: scans req_vec starting at prio_ptr and returns the first
// requesting channel as a one-hot grant plus its encoded index.
module dma_prio_arbiter
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] req_vec,
  input  ch_idx_t           prio_ptr,
  output logic [NUM_CH-1:0] grant,
  output ch_idx_t           grant_idx
);

  logic found;

  // NOTE: every output gets a default before the search loop, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin : scan
      ch_idx_t cand;
      cand = ch_idx_t'(prio_ptr + ch_idx_t'(i));
      if (!found && req_vec[cand]) begin
        found           = 1'b1;
        grant_idx       = cand;
        grant[cand]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// DMA channel priority resolver: IDLE/REQ/SERVICE handshake with timing control.
// Define DMA_ROTATE_PRIO_EN to build the rotating-priority pointer (rotateEn selects mode).
module dma_priority_resolver
  import dma_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  DREQ,
  input  logic        dreqSenseLow,
  input  logic        dackSenseHigh,
  input  logic        ctrlDisable,
  input  logic        rotateEn,
  input  logic [3:0]  maskReg,
  input  logic [3:0]  swReq,
  input  logic        hrq,
  input  logic        validDACK,
  input  logic        svcDone,
  output logic        VALID_DREQ0,
  output logic        VALID_DREQ1,
  output logic        VALID_DREQ2,
  output logic        VALID_DREQ3,
  output logic [3:0]  DACK,
  output logic [1:0]  activeCh
);

  logic [NUM_CH-1:0] req_vec;
  logic [NUM_CH-1:0] arb_grant;
  ch_idx_t           arb_idx;
  ch_idx_t           arb_ptr;
  ch_idx_t           win_ch;
  dma_state_t        state;
  logic [NUM_CH-1:0] valid_q;
  logic [NUM_CH-1:0] dack_q;
  logic              svc_end;

  assign req_vec = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | swReq;
  assign svc_end = (state == SERVICE) && svcDone;

  dma_prio_arbiter u_arbiter (
    .req_vec   (req_vec),
    .prio_ptr  (arb_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

`ifdef DMA_ROTATE_PRIO_EN
  ch_idx_t prio_ptr;

  // Pointer always tracks the channel after the last one served; rotateEn only
  // decides at arbitration time whether it is honoured.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      prio_ptr <= '0;
    end else if (svc_end) begin
      prio_ptr <= next_ch(win_ch);
    end
  end

  assign arb_ptr = rotateEn ? prio_ptr : '0;
`else
  logic unused_rotate_en;

  assign unused_rotate_en = rotateEn;
  assign arb_ptr          = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      win_ch  <= '0;
      valid_q <= '0;
      dack_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((|req_vec) && !ctrlDisable) begin
            state   <= REQ;
            win_ch  <= arb_idx;
            valid_q <= arb_grant;
          end
        end
        REQ: begin
          // Winner stays latched; only its own request or the handshake matter here.
          if (hrq && validDACK) begin
            state  <= SERVICE;
            dack_q <= valid_q;
          end else if (!req_vec[win_ch] && !hrq) begin
            state   <= IDLE;
            valid_q <= '0;
          end
        end
        SERVICE: begin
          if (svcDone) begin
            state   <= IDLE;
            valid_q <= '0;
            dack_q  <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= '0;
          dack_q  <= '0;
        end
      endcase
    end
  end

  assign VALID_DREQ0 = valid_q[0];
  assign VALID_DREQ1 = valid_q[1];
  assign VALID_DREQ2 = valid_q[2];
  assign VALID_DREQ3 = valid_q[3];

  // Inactive bits sit at the inverse of dackSenseHigh.
  assign DACK     = dack_q ^ {NUM_CH{~dackSenseHigh}};
  assign activeCh = win_ch;

endmodule
